// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with a tenure limit. A holder that keeps requesting
// past TENURE_MAX is rotated out once it is no longer busy.
module bus_arbiter_rr #(
    parameter int TENURE_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] busy,
    output logic [3:0] grnt,
    output logic [1:0] owner,
    output logic       grnt_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] TMAX = 8'(TENURE_MAX);

    state_t     state, state_n;
    logic [3:0] grnt_n;
    logic [1:0] owner_n;
    logic [7:0] tenure, tenure_n;
    logic       preempt_n;
    logic [3:0] others;
    logic [1:0] pick_all;
    logic [1:0] pick_oth;

    // Searches last+1, last+2, last+3 and finally last itself; the closest candidate wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (cand[idx]) rr_pick = idx;
        end
    endfunction

    assign others   = req & ~grnt;
    assign pick_all = rr_pick(req, owner);
    assign pick_oth = rr_pick(others, owner);

    // grnt_valid is the registered state itself, so it doubles as the FSM debug view.
    assign grnt_valid = (state == GRANT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grnt    <= 4'b0000;
            owner   <= 2'd3;
            tenure  <= 8'd0;
            preempt <= 1'b0;
        end else begin
            state   <= state_n;
            grnt    <= grnt_n;
            owner   <= owner_n;
            tenure  <= tenure_n;
            preempt <= preempt_n;
        end
    end

    always_comb begin
        state_n   = state;
        grnt_n    = grnt;
        owner_n   = owner;
        tenure_n  = tenure;
        preempt_n = 1'b0;
        case (state)
            IDLE: begin
                grnt_n = 4'b0000;
                if (|req) begin
                    state_n  = GRANT;
                    grnt_n   = 4'b0001 << pick_all;
                    owner_n  = pick_all;
                    tenure_n = 8'd0;
                end
            end
            GRANT: begin
                tenure_n = (tenure == TMAX) ? tenure : tenure + 8'd1;
                if (!req[owner]) begin
                    // Release wins over busy; hand straight to the next requester if any.
                    if (|others) begin
                        grnt_n   = 4'b0001 << pick_oth;
                        owner_n  = pick_oth;
                        tenure_n = 8'd0;
                    end else begin
                        state_n  = IDLE;
                        grnt_n   = 4'b0000;
                        tenure_n = 8'd0;
                    end
                end else if (tenure == TMAX && !busy[owner] && |others) begin
                    grnt_n    = 4'b0001 << pick_oth;
                    owner_n   = pick_oth;
                    tenure_n  = 8'd0;
                    preempt_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grnt_n  = 4'b0000;
            end
        endcase
    end

endmodule
